cmd_gen_mux: RTL and testbench

Parametrised, single-clock successor of the 40→160 command path. It has NUM_CH independent command-word generators, each able to run as an LFSR or as a counter. Each generator writes into its own channel FIFO. A round-robin arbiter merges the FIFOs into one output stream with valid/ready handshaking and a channel tag. It sits in the off-chip stimulus path, in the consumer clock domain, and replaces the per-link LFSR+FIFO pair when several emulated links are driven at once.

---
 rtl/cmd_gen_pkg.sv | 38 +++
 rtl/cmd_chan_fifo.sv | 60 ++++++
 rtl/cmd_gen_mux.sv | 146 ++++++++++++++
 tb/tb_cmd_gen_mux.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_gen_pkg.sv
// Shared types and elaboration helpers for the multi-channel command generator.
package cmd_gen_pkg;

    typedef enum logic {
        MODE_LFSR = 1'b0,
        MODE_CNT  = 1'b1
    } gen_mode_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Tap mask for a left-shifting Fibonacci LFSR; bit k-1 set for each x^k term.
    function automatic logic [31:0] lfsr_taps(input int unsigned width);
        case (width)
            8:       return 32'h0000_00B8;
            16:      return 32'h0000_B400;
            32:      return 32'h8020_0003;
            default: return 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [31:0] lfsr_seed(input logic [31:0] base,
                                              input int unsigned ch,
                                              input int unsigned width);
        logic [31:0] mask;
        logic [31:0] s;
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        s    = (base ^ ch) & mask;
        return (s == 32'd0) ? 32'd1 : s;
    endfunction

endpackage

// File: rtl/cmd_chan_fifo.sv
// Single-clock channel FIFO with show-ahead read data and a registered full flag.
module cmd_chan_fifo
    import cmd_gen_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int unsigned AW = clog2(FIFO_DEPTH);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("cmd_chan_fifo: FIFO_DEPTH must be a power of 2 and at least 2");
    end

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]       wptr;
    logic [AW:0]       rptr;
    logic [AW:0]       wptr_nxt;
    logic [AW:0]       rptr_nxt;
    logic              wr_en;
    logic              rd_en;

    // Writes see the registered full flag, so a same-cycle pop cannot make room.
    assign wr_en    = push & ~full;
    assign rd_en    = pop & ~empty;
    assign wptr_nxt = wptr + {{AW{1'b0}}, wr_en};
    assign rptr_nxt = rptr + {{AW{1'b0}}, rd_en};

    assign empty = (wptr == rptr);
    assign dout  = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
            full <= 1'b0;
        end else begin
            wptr <= wptr_nxt;
            rptr <= rptr_nxt;
            full <= (wptr_nxt[AW] != rptr_nxt[AW]) &&
                    (wptr_nxt[AW-1:0] == rptr_nxt[AW-1:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/cmd_gen_mux.sv
// Multi-channel command generator: per-channel LFSR/counter sources feeding
// channel FIFOs, merged round-robin into one valid/ready output stream.
module cmd_gen_mux
    import cmd_gen_pkg::*;
#(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] SEED_BASE  = 32'h0000_ACE1,
    localparam int unsigned CH_W      = (clog2(NUM_CH) > 1) ? clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] gen_cmd,
    input  logic [NUM_CH-1:0] mode,
    input  logic              rd_cmd,
    output logic              cmd_valid,
    output logic [DATA_W-1:0] cmd_data,
    output logic [CH_W-1:0]   cmd_ch,
    output logic [NUM_CH-1:0] fifo_full,
    output logic [NUM_CH-1:0] ovf,
    input  logic [NUM_CH-1:0] clr_ovf
);

    localparam int unsigned       CW1       = CH_W + 1;
    localparam logic [31:0]       TAPS_FULL = lfsr_taps(DATA_W);
    localparam logic [DATA_W-1:0] TAPS      = TAPS_FULL[DATA_W-1:0];

    if (!(DATA_W == 8 || DATA_W == 16 || DATA_W == 32)) begin : g_bad_data_w
        $error("cmd_gen_mux: DATA_W must be 8, 16 or 32");
    end

    if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
        $error("cmd_gen_mux: NUM_CH must be in 1..8");
    end

    logic [DATA_W-1:0] fifo_dout [NUM_CH];
    logic [NUM_CH-1:0] fifo_empty;
    logic [NUM_CH-1:0] pop_vec;
    logic [CH_W-1:0]   last_grant;
    logic [CH_W-1:0]   grant_idx;
    logic              grant_found;
    logic              load;
    logic [CW1-1:0]    cand;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [31:0]       SEED_FULL = lfsr_seed(SEED_BASE, i, DATA_W);
        localparam logic [DATA_W-1:0] SEED      = SEED_FULL[DATA_W-1:0];

        logic [DATA_W-1:0] lfsr_q;
        logic [DATA_W-1:0] cnt_q;
        logic [DATA_W-1:0] word;
        logic              accept;
        logic              drop;
        logic              ovf_q;
        gen_mode_e         sel;

        assign sel    = gen_mode_e'(mode[i]);
        assign accept = gen_cmd[i] & ~fifo_full[i];
        assign drop   = gen_cmd[i] &  fifo_full[i];
        assign word   = (sel == MODE_CNT) ? cnt_q : lfsr_q;

        // Only the register whose value was emitted advances.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                lfsr_q <= SEED;
                cnt_q  <= '0;
            end else if (accept) begin
                if (sel == MODE_CNT) begin
                    cnt_q <= cnt_q + DATA_W'(1);
                end else begin
                    lfsr_q <= {lfsr_q[DATA_W-2:0], ^(lfsr_q & TAPS)};
                end
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                ovf_q <= 1'b0;
            end else if (drop) begin
                ovf_q <= 1'b1;
            end else if (clr_ovf[i]) begin
                ovf_q <= 1'b0;
            end
        end

        assign ovf[i] = ovf_q;

        cmd_chan_fifo #(
            .DATA_W     (DATA_W),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (gen_cmd[i]),
            .din   (word),
            .pop   (pop_vec[i]),
            .dout  (fifo_dout[i]),
            .full  (fifo_full[i]),
            .empty (fifo_empty[i])
        );
    end

    assign load = ~cmd_valid | rd_cmd;

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            cand = {1'b0, last_grant} + CW1'(k);
            if (cand >= CW1'(NUM_CH)) begin
                cand = cand - CW1'(NUM_CH);
            end
            if (!grant_found && !fifo_empty[cand[CH_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[CH_W-1:0];
            end
        end
    end

    always_comb begin
        pop_vec = '0;
        if (load && grant_found) begin
            pop_vec = NUM_CH'(1) << grant_idx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_valid  <= 1'b0;
            cmd_data   <= '0;
            cmd_ch     <= '0;
            last_grant <= CH_W'(NUM_CH - 1);
        end else if (load) begin
            cmd_valid <= grant_found;
            if (grant_found) begin
                cmd_data   <= fifo_dout[grant_idx];
                cmd_ch     <= grant_idx;
                last_grant <= grant_idx;
            end
        end
    end

endmodule

// File: tb/tb_cmd_gen_mux.sv
// Randomized bench for cmd_gen_mux against a queue-based behavioural model,
// plus an 8-bit instance exercising counter wrap.
module tb_cmd_gen_mux;

    localparam int NCH   = 4;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  gen_cmd;
    logic [3:0]  mode;
    logic        rd_cmd;
    logic [3:0]  clr_ovf;
    logic        cmd_valid;
    logic [15:0] cmd_data;
    logic [1:0]  cmd_ch;
    logic [3:0]  fifo_full;
    logic [3:0]  ovf;

    logic [3:0]  gen8;
    logic [3:0]  mode8;
    logic        rd8;
    logic [3:0]  clr8;
    logic        valid8;
    logic [7:0]  data8;
    logic [1:0]  ch8;
    logic [3:0]  full8;
    logic [3:0]  ovf8;

    always #5 clk = ~clk;

    cmd_gen_mux #(
        .NUM_CH     (4),
        .DATA_W     (16),
        .FIFO_DEPTH (8),
        .SEED_BASE  (32'h0000_ACE1)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .gen_cmd   (gen_cmd),
        .mode      (mode),
        .rd_cmd    (rd_cmd),
        .cmd_valid (cmd_valid),
        .cmd_data  (cmd_data),
        .cmd_ch    (cmd_ch),
        .fifo_full (fifo_full),
        .ovf       (ovf),
        .clr_ovf   (clr_ovf)
    );

    cmd_gen_mux #(
        .NUM_CH     (4),
        .DATA_W     (8),
        .FIFO_DEPTH (8),
        .SEED_BASE  (32'h0000_ACE1)
    ) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .gen_cmd   (gen8),
        .mode      (mode8),
        .rd_cmd    (rd8),
        .cmd_valid (valid8),
        .cmd_data  (data8),
        .cmd_ch    (ch8),
        .fifo_full (full8),
        .ovf       (ovf8),
        .clr_ovf   (clr8)
    );

    int n_vec  = 0;
    int n_err  = 0;
    int n_xfer = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: pending words kept in global arrival order, tagged by channel.
    typedef struct {
        int          ch;
        logic [15:0] w;
    } item_t;

    item_t       pend[$];
    logic [15:0] m_lfsr [NCH];
    logic [15:0] m_cnt  [NCH];
    logic [3:0]  m_ovf;
    logic        m_valid;
    logic [15:0] m_data;
    int          m_ch;
    int          m_last;

    function automatic int count_ch(input int ch);
        int n = 0;
        foreach (pend[j]) if (pend[j].ch == ch) n++;
        return n;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        int ex[4];
        bit fb;
        ex = '{16, 14, 13, 11};
        fb = 1'b0;
        foreach (ex[j]) fb = fb ^ s[ex[j] - 1];
        return {s[14:0], fb};
    endfunction

    task automatic model_reset();
        pend.delete();
        for (int i = 0; i < NCH; i++) begin
            m_lfsr[i] = 16'hACE1 ^ 16'(i);
            m_cnt[i]  = 16'h0000;
        end
        m_ovf   = 4'b0000;
        m_valid = 1'b0;
        m_data  = 16'h0000;
        m_ch    = 0;
        m_last  = NCH - 1;
    endtask

    task automatic model_step(input logic [3:0] g, input logic [3:0] m,
                              input logic rd, input logic [3:0] c);
        int fill[NCH];
        bit found;
        int gch;
        for (int i = 0; i < NCH; i++) fill[i] = count_ch(i);
        if (!m_valid || rd) begin
            found = 1'b0;
            gch   = 0;
            for (int k = 1; k <= NCH; k++) begin
                int cc = (m_last + k) % NCH;
                if (!found && fill[cc] > 0) begin
                    found = 1'b1;
                    gch   = cc;
                end
            end
            if (found) begin
                for (int j = 0; j < pend.size(); j++) begin
                    if (pend[j].ch == gch) begin
                        m_data = pend[j].w;
                        pend.delete(j);
                        break;
                    end
                end
                m_ch    = gch;
                m_last  = gch;
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
        end
        for (int i = 0; i < NCH; i++) begin
            if (g[i] && fill[i] < DEPTH) begin
                item_t it;
                it.ch = i;
                if (m[i]) begin
                    it.w     = m_cnt[i];
                    m_cnt[i] = m_cnt[i] + 16'd1;
                end else begin
                    it.w      = m_lfsr[i];
                    m_lfsr[i] = lfsr_next(m_lfsr[i]);
                end
                pend.push_back(it);
            end
            if (g[i] && fill[i] >= DEPTH) m_ovf[i] = 1'b1;
            else if (c[i])                m_ovf[i] = 1'b0;
        end
    endtask

    task automatic compare_outputs();
        logic [3:0] exp_full;
        for (int i = 0; i < NCH; i++) exp_full[i] = (count_ch(i) == DEPTH);
        check("cmd_valid", cmd_valid, m_valid);
        check("cmd_data",  cmd_data,  m_data);
        check("cmd_ch",    cmd_ch,    m_ch);
        check("fifo_full", fifo_full, exp_full);
        check("ovf",       ovf,       m_ovf);
    endtask

    // Called at a falling edge: drive, sample the state left by the last rising edge, advance model.
    task automatic cyc(input logic r, input logic [3:0] g, input logic [3:0] m,
                       input logic rd, input logic [3:0] c);
        rst     = r;
        gen_cmd = g;
        mode    = m;
        rd_cmd  = rd;
        clr_ovf = c;
        #1;
        if (!r) model_reset();
        compare_outputs();
        if (cmd_valid && rd_cmd) n_xfer++;
        if (r) model_step(g, m, rd, c);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] g;
        logic [3:0] m;
        logic [3:0] c;
        logic       rdv;
        logic [7:0] exp8;
        int         n8;

        rst = 1'b0; gen_cmd = '0; mode = '0; rd_cmd = 1'b0; clr_ovf = '0;
        gen8 = '0; mode8 = '0; rd8 = 1'b0; clr8 = '0;
        model_reset();
        @(negedge clk);
        repeat (3) cyc(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000);

        // First LFSR words from channel 0.
        cyc(1'b1, 4'b0001, 4'b0000, 1'b1, 4'b0000);
        cyc(1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000);
        #1;
        check("seed_valid", cmd_valid, 1);
        check("seed_word",  cmd_data,  16'hACE1);
        check("seed_ch",    cmd_ch,    0);
        cyc(1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000);
        cyc(1'b1, 4'b0001, 4'b0000, 1'b1, 4'b0000);
        cyc(1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000);
        #1;
        check("second_word", cmd_data, 16'h59C3);
        cyc(1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000);

        // Fill channel 2 with the output stalled; the 10th strobe drops while clr_ovf is high.
        for (int k = 0; k < 10; k++)
            cyc(1'b1, 4'b0100, 4'b0000, 1'b0, (k == 9) ? 4'b0100 : 4'b0000);
        #1;
        check("ovf2_set_wins", ovf[2],       1);
        check("full2",         fifo_full[2], 1);
        n_xfer = 0;
        repeat (12) cyc(1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000);
        check("drain_count", n_xfer, 9);

        // Round-robin fairness.
        repeat (3) cyc(1'b1, 4'b1111, 4'b0000, 1'b0, 4'b1111);
        n_xfer = 0;
        repeat (14) cyc(1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000);
        check("rr_count", n_xfer, 12);

        // Random traffic with backpressure, mode switching and overflow clears.
        for (int k = 0; k < 1500; k++) begin
            g   = 4'($urandom) & 4'($urandom);
            m   = 4'($urandom);
            rdv = (k < 750) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            c   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
            cyc(1'b1, g, m, rdv, c);
        end

        // Mid-stream asynchronous reset.
        repeat (40) cyc(1'b1, 4'b0000, 4'b0000, 1'b1, 4'b1111);
        repeat (4)  cyc(1'b1, 4'b1111, 4'b0000, 1'b0, 4'b0000);
        check("pre_rst_valid", cmd_valid, 1);
        rst = 1'b0;
        #1;
        check("rst_valid", cmd_valid, 0);
        check("rst_data",  cmd_data,  0);
        check("rst_ch",    cmd_ch,    0);
        check("rst_full",  fifo_full, 0);
        check("rst_ovf",   ovf,       0);
        model_reset();
        repeat (2) cyc(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000);
        cyc(1'b1, 4'b0001, 4'b0000, 1'b1, 4'b0000);
        cyc(1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000);
        #1;
        check("seed_after_rst", cmd_data, 16'hACE1);
        check("ch_after_rst",   cmd_ch,   0);
        repeat (3) cyc(1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0000);
        gen_cmd = '0;
        rd_cmd  = 1'b0;

        // 8-bit counter wrap on channel 1.
        exp8  = 8'd0;
        n8    = 0;
        mode8 = 4'b0010;
        rd8   = 1'b1;
        for (int k = 0; k < 262; k++) begin
            gen8 = (k < 257) ? 4'b0010 : 4'b0000;
            #1;
            if (valid8 && rd8) begin
                check("cnt8_data", data8, exp8);
                check("cnt8_ch",   ch8,   1);
                exp8 = exp8 + 8'd1;
                n8++;
            end
            @(negedge clk);
        end
        check("cnt8_words", n8,   257);
        check("cnt8_ovf",   ovf8, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
